// File: rtl/full_adder_pkg.sv
// ----------------------------------------------------------------------------
// full_adder_pkg
//
// Purpose : Shared constants for the full_adder block: the default operand
//           width and the legal width range, plus a helper that tells whether
//           a given width is inside that range.
//
// Contents:
//   FA_DEFAULT_WIDTH - default operand width in bits
//   FA_WIDTH_MIN     - smallest legal operand width
//   FA_WIDTH_MAX     - largest legal operand width
//   fa_width_legal() - 1 when a width lies inside [FA_WIDTH_MIN, FA_WIDTH_MAX]
// ----------------------------------------------------------------------------
package full_adder_pkg;

   localparam int unsigned FA_DEFAULT_WIDTH = 1;
   localparam int unsigned FA_WIDTH_MIN     = 1;
   localparam int unsigned FA_WIDTH_MAX     = 64;

   function automatic bit fa_width_legal(input int unsigned w);
      return (w >= FA_WIDTH_MIN) && (w <= FA_WIDTH_MAX);
   endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// ----------------------------------------------------------------------------
// fa_cell
//
// Purpose : One-bit full adder, the repeated stage of the full_adder ripple
//           chain.
//
// Ports   :
//   a     in  1  addend bit A
//   b     in  1  addend bit B
//   cin   in  1  carry into this bit
//   sum   out 1  sum bit (a ^ b ^ cin)
//   carry out 1  carry out of this bit (majority of a, b, cin)
// ----------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//
// Purpose : WIDTH-bit unsigned ripple-carry adder with a combinational result
//           and an optional registered copy of that result.
//
// Parameters:
//   WIDTH   operand width in bits, legal range 1..64
//   REG_OUT 1 = registered copies present, 0 = registered outputs tied to 0
//
// Ports   :
//   clk       in  1      rising-edge clock for the registered outputs
//   rst_n     in  1      asynchronous active-low reset (registered path only)
//   a         in  WIDTH  addend A, unsigned
//   b         in  WIDTH  addend B, unsigned
//   cin       in  1      carry-in
//   en        in  1      capture strobe for the registered path
//   sum       out WIDTH  combinational sum bits
//   carry     out 1      combinational carry-out
//   sum_q     out WIDTH  registered sum
//   carry_q   out 1      registered carry-out
//   out_valid out 1      registered-result-valid flag
//
// Valid semantics: there is no ready and no backpressure. en is sampled on
// every rising edge; out_valid is simply en delayed by one cycle, so it is
// high in exactly the cycles that follow an en cycle and stays high through
// back-to-back en cycles. When en is low, sum_q/carry_q keep the last captured
// result but out_valid drops, so consumers must qualify sum_q with out_valid.
// ----------------------------------------------------------------------------
module full_adder
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH   = FA_DEFAULT_WIDTH,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             en,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [WIDTH-1:0] sum_q,
   output logic             carry_q,
   output logic             out_valid
);

   // Elaboration-time guard: an out-of-range width stops the build here
   // instead of producing a silently odd netlist.
   generate
      if (!fa_width_legal(WIDTH)) begin : g_bad_width
         $error("full_adder: WIDTH=%0d outside legal range %0d..%0d",
                WIDTH, FA_WIDTH_MIN, FA_WIDTH_MAX);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Ripple chain: chain[i] is the carry into bit i, chain[WIDTH] is the
   // carry out of the top bit. Purely combinational, so clk/en/rst_n have no
   // effect on sum/carry.
   // ------------------------------------------------------------------------
   logic [WIDTH:0] chain;

   assign chain[0] = cin;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         fa_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .cin   (chain[i]),
            .sum   (sum[i]),
            .carry (chain[i+1])
         );
      end
   endgenerate

   assign carry = chain[WIDTH];

   // ------------------------------------------------------------------------
   // Register stage. Reset is asynchronous and wins over en; the result
   // registers only load on en, while out_valid follows en every edge.
   // ------------------------------------------------------------------------
   generate
      if (REG_OUT) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_q     <= '0;
               carry_q   <= 1'b0;
               out_valid <= 1'b0;
            end else begin
               out_valid <= en;
               if (en) begin
                  sum_q   <= sum;
                  carry_q <= carry;
               end
            end
         end
      end else begin : g_no_reg
         assign sum_q     = '0;
         assign carry_q   = 1'b0;
         assign out_valid = 1'b0;
      end
   endgenerate

endmodule : full_adder

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
//
// Exercises three full_adder instances sharing one clock and reset:
//   dut1  WIDTH=1,  REG_OUT=1
//   dut8  WIDTH=8,  REG_OUT=1   (dut0 shares its inputs with REG_OUT=0)
//   dut64 WIDTH=64, REG_OUT=1
// Expected values come from plain a+b+cin arithmetic; the registered path is
// modelled as "last value captured on an en cycle" held in an expected queue.
// ----------------------------------------------------------------------------
module tb_full_adder;

   // -------------------------------------------------------------- clock/reset
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // -------------------------------------------------------------- DUT signals
   logic        a1, b1, cin1, en1;
   logic        sum1, carry1, sum_q1, carry_q1, valid1;

   logic [7:0]  a8, b8;
   logic        cin8, en8;
   logic [7:0]  sum8, sum_q8;
   logic        carry8, carry_q8, valid8;

   logic [7:0]  sum0, sum_q0;
   logic        carry0, carry_q0, valid0;

   logic [63:0] a64, b64;
   logic        cin64, en64;
   logic [63:0] sum64, sum_q64;
   logic        carry64, carry_q64, valid64;

   full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .en(en1),
      .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
      .out_valid(valid1)
   );

   full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .en(en8),
      .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
      .out_valid(valid8)
   );

   full_adder #(.WIDTH(8), .REG_OUT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .en(en8),
      .sum(sum0), .carry(carry0), .sum_q(sum_q0), .carry_q(carry_q0),
      .out_valid(valid0)
   );

   full_adder #(.WIDTH(64), .REG_OUT(1'b1)) dut64 (
      .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .cin(cin64), .en(en64),
      .sum(sum64), .carry(carry64), .sum_q(sum_q64), .carry_q(carry_q64),
      .out_valid(valid64)
   );

   // -------------------------------------------------------------- scoreboard
   int errors = 0;
   int checks = 0;

   logic [8:0]  exp_q8[$];
   logic [64:0] exp_q64[$];
   logic [1:0]  exp_q1[$];

   // Reference: unsigned sum at full width plus one carry bit.
   function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic c);
      return 9'(x) + 9'(y) + 9'(c);
   endfunction

   function automatic logic [64:0] ref64(input logic [63:0] x, input logic [63:0] y,
                                         input logic c);
      return 65'(x) + 65'(y) + 65'(c);
   endfunction

   function automatic logic [1:0] ref1(input logic x, input logic y, input logic c);
      return 2'(x) + 2'(y) + 2'(c);
   endfunction

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; en1 = 1'b1;
      a8 = 8'h5a; b8 = 8'hc3; cin8 = 1'b1; en8 = 1'b1;
      a64 = 64'hffff_0000_ffff_0000; b64 = 64'h0001_0000_0001_0000;
      cin64 = 1'b0; en64 = 1'b1;
      // Two edges with en=1 while held in reset: reset must win.
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({carry_q8, sum_q8, valid8} !== 10'd0) begin
         errors++;
         $display("FAIL reset_dut8: got q=%b_%h v=%b expected 0_00 v=0",
                  carry_q8, sum_q8, valid8);
      end
      checks++;
      if ({carry_q1, sum_q1, valid1} !== 3'd0) begin
         errors++;
         $display("FAIL reset_dut1: got %b%b%b expected 000", carry_q1, sum_q1, valid1);
      end
      checks++;
      if ({carry_q64, sum_q64, valid64} !== 66'd0) begin
         errors++;
         $display("FAIL reset_dut64: got q=%b_%h v=%b expected zeros",
                  carry_q64, sum_q64, valid64);
      end
      // Combinational path runs regardless of reset.
      checks++;
      if ({carry8, sum8} !== ref8(a8, b8, cin8)) begin
         errors++;
         $display("FAIL reset_comb8: got %h expected %h", {carry8, sum8}, ref8(a8, b8, cin8));
      end
      checks++;
      if ({carry64, sum64} !== ref64(a64, b64, cin64)) begin
         errors++;
         $display("FAIL reset_comb64: got %h expected %h",
                  {carry64, sum64}, ref64(a64, b64, cin64));
      end
      @(negedge clk);
      en1 = 1'b0; en8 = 1'b0; en64 = 1'b0;
      rst_n = 1'b1;
      // First edge after reset with en=0: no capture, no valid.
      @(posedge clk);
      #1;
      checks++;
      if ({carry_q8, sum_q8, valid8} !== 10'd0) begin
         errors++;
         $display("FAIL reset_release_no_en: got q=%b_%h v=%b expected 0_00 v=0",
                  carry_q8, sum_q8, valid8);
      end
   endtask

   task automatic test_truth_table_w1();
      logic [1:0] tt [8];
      logic [2:0] k;
      // Pairs are {sum, carry} for {a, b, cin} = 000 .. 111.
      tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         k = 3'(i);
         {a1, b1, cin1} = k;
         #1;
         checks++;
         if ({sum1, carry1} !== tt[i]) begin
            errors++;
            $display("FAIL truth_table abc=%b: got sum,carry=%b%b expected %b",
                     k, sum1, carry1, tt[i]);
         end
      end
   endtask

   task automatic test_wrap_capture();
      @(negedge clk);
      a8 = 8'hff; b8 = 8'h01; cin8 = 1'b0; en8 = 1'b1;
      #1;
      checks++;
      if ({carry8, sum8} !== 9'h100) begin
         errors++;
         $display("FAIL wrap_comb: got carry=%b sum=%h expected carry=1 sum=00", carry8, sum8);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({carry_q8, sum_q8, valid8} !== {1'b1, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL wrap_reg: got q=%b_%h v=%b expected 1_00 v=1",
                  carry_q8, sum_q8, valid8);
      end
      checks++;
      if ({carry_q0, sum_q0, valid0} !== 10'd0) begin
         errors++;
         $display("FAIL reg_out0: got q=%b_%h v=%b expected zeros", carry_q0, sum_q0, valid0);
      end
      checks++;
      if ({carry0, sum0} !== 9'h100) begin
         errors++;
         $display("FAIL reg_out0_comb: got %h expected 100", {carry0, sum0});
      end
   endtask

   task automatic test_boundaries();
      @(negedge clk);
      en8 = 1'b0;
      a8 = 8'hff; b8 = 8'hff; cin8 = 1'b1;
      a64 = '1; b64 = '1; cin64 = 1'b1;
      #1;
      checks++;
      if ({carry8, sum8} !== 9'h1ff) begin
         errors++;
         $display("FAIL ones8: got %h expected 1ff", {carry8, sum8});
      end
      checks++;
      if ({carry64, sum64} !== {1'b1, 64'hffff_ffff_ffff_ffff}) begin
         errors++;
         $display("FAIL ones64: got %h expected 1ffffffffffffffff", {carry64, sum64});
      end
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
      a64 = '0; b64 = '0; cin64 = 1'b0;
      #1;
      checks++;
      if ({carry8, sum8} !== 9'h000) begin
         errors++;
         $display("FAIL zeros8: got %h expected 000", {carry8, sum8});
      end
      checks++;
      if ({carry64, sum64} !== 65'd0) begin
         errors++;
         $display("FAIL zeros64: got %h expected 0", {carry64, sum64});
      end
   endtask

   task automatic test_pulse_hold();
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; en8 = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({carry_q8, sum_q8, valid8} !== {1'b0, 8'd7, 1'b1}) begin
         errors++;
         $display("FAIL pulse_capture: got q=%b_%h v=%b expected 0_07 v=1",
                  carry_q8, sum_q8, valid8);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         checks++;
         if ({carry_q8, sum_q8, valid8} !== {1'b0, 8'd7, 1'b0}) begin
            errors++;
            $display("FAIL pulse_hold cycle %0d: got q=%b_%h v=%b expected 0_07 v=0",
                     i, carry_q8, sum_q8, valid8);
         end
         // Input wiggle between edges must not reach the registers.
         #2;
         a8 = ~a8; b8 = b8 + 8'd1;
         #1;
         checks++;
         if ({carry_q8, sum_q8} !== 9'd7) begin
            errors++;
            $display("FAIL midcycle_inputs cycle %0d: got q=%b_%h expected 0_07",
                     i, carry_q8, sum_q8);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
         en8 = 1'b1;
         exp = ref8(a8, b8, cin8);
         @(posedge clk);
         #1;
         checks++;
         if ({carry_q8, sum_q8, valid8} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back %0d: got q=%h v=%b expected q=%h v=1",
                     i, {carry_q8, sum_q8}, valid8, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [8:0] comb_before;
      // Registers hold a valid result from the back-to-back run; en stays high.
      #3;
      comb_before = {carry8, sum8};
      rst_n = 1'b0;
      #1;
      checks++;
      if ({carry_q8, sum_q8, valid8} !== 10'd0) begin
         errors++;
         $display("FAIL async_reset: got q=%b_%h v=%b expected zeros immediately",
                  carry_q8, sum_q8, valid8);
      end
      checks++;
      if ({carry8, sum8} !== comb_before) begin
         errors++;
         $display("FAIL async_reset_comb: got %h expected %h", {carry8, sum8}, comb_before);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({carry_q8, sum_q8, valid8} !== 10'd0) begin
         errors++;
         $display("FAIL reset_over_en: got q=%b_%h v=%b expected zeros",
                  carry_q8, sum_q8, valid8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en8 = 1'b0; en1 = 1'b0; en64 = 1'b0;
   endtask

   task automatic test_random();
      logic [8:0]  held8  = '0;
      logic [64:0] held64 = '0;
      logic [1:0]  held1  = '0;
      logic [8:0]  e8;
      logic [64:0] e64;
      logic [1:0]  e1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
         cin8 = 1'($urandom_range(0, 1)); en8 = 1'($urandom_range(0, 1));
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
         cin64 = 1'($urandom_range(0, 1)); en64 = 1'($urandom_range(0, 1));
         a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
         cin1 = 1'($urandom_range(0, 1)); en1 = 1'($urandom_range(0, 1));
         e8 = ref8(a8, b8, cin8);
         e64 = ref64(a64, b64, cin64);
         e1 = ref1(a1, b1, cin1);
         #1;
         checks++;
         if ({carry8, sum8} !== e8) begin
            errors++;
            $display("FAIL rand_comb8 %0d: a=%h b=%h cin=%b got %h expected %h",
                     i, a8, b8, cin8, {carry8, sum8}, e8);
         end
         checks++;
         if ({carry64, sum64} !== e64) begin
            errors++;
            $display("FAIL rand_comb64 %0d: got %h expected %h", i, {carry64, sum64}, e64);
         end
         checks++;
         if ({carry1, sum1} !== e1) begin
            errors++;
            $display("FAIL rand_comb1 %0d: got %b expected %b", i, {carry1, sum1}, e1);
         end
         if (en8)  exp_q8.push_back(e8);
         if (en64) exp_q64.push_back(e64);
         if (en1)  exp_q1.push_back(e1);
         @(posedge clk);
         #1;
         if (exp_q8.size() > 0)  held8  = exp_q8.pop_front();
         if (exp_q64.size() > 0) held64 = exp_q64.pop_front();
         if (exp_q1.size() > 0)  held1  = exp_q1.pop_front();
         checks++;
         if ({carry_q8, sum_q8, valid8} !== {held8, en8}) begin
            errors++;
            $display("FAIL rand_reg8 %0d: got q=%h v=%b expected q=%h v=%b",
                     i, {carry_q8, sum_q8}, valid8, held8, en8);
         end
         checks++;
         if ({carry_q64, sum_q64, valid64} !== {held64, en64}) begin
            errors++;
            $display("FAIL rand_reg64 %0d: got q=%h v=%b expected q=%h v=%b",
                     i, {carry_q64, sum_q64}, valid64, held64, en64);
         end
         checks++;
         if ({carry_q1, sum_q1, valid1} !== {held1, en1}) begin
            errors++;
            $display("FAIL rand_reg1 %0d: got q=%b v=%b expected q=%b v=%b",
                     i, {carry_q1, sum_q1}, valid1, held1, en1);
         end
         checks++;
         if ({carry_q0, sum_q0, valid0} !== 10'd0) begin
            errors++;
            $display("FAIL rand_reg_out0 %0d: got q=%h v=%b expected zeros",
                     i, {carry_q0, sum_q0}, valid0);
         end
      end
   endtask

   // -------------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_truth_table_w1();
      test_wrap_capture();
      test_boundaries();
      test_pulse_hold();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_full_adder

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Parameter REG_OUT, default 1; 1 = registered copies present, 0 = registered outputs tied to 0.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all registered outputs.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  WIDTH  addend A, unsigned.
REQ-007 b  input  WIDTH  addend B, unsigned.
REQ-008 cin  input  1  carry-in.
REQ-009 en  input  1  capture strobe for the registered path.
REQ-010 sum  output  WIDTH  combinational sum bits.
REQ-011 carry  output  1  combinational carry-out.
REQ-012 sum_q  output  WIDTH  registered sum.
REQ-013 carry_q  output  1  registered carry-out.
REQ-014 out_valid  output  1  registered-result-valid flag.

Function
REQ-015 {carry, sum} SHALL equal a + b + cin, computed at WIDTH+1 bits, with no truncation of the carry.
REQ-016 sum and carry SHALL be purely combinational, with zero clock latency, and SHALL be independent of clk, en and rst_n.
REQ-017 For WIDTH=1: sum = a XOR b XOR cin; carry = majority(a, b, cin).
REQ-018 The adder SHALL be built as a ripple chain: bit i carry-out feeds bit i+1 carry-in; bit 0 takes cin; the last stage drives carry.
REQ-019 On a rising clk edge with en=1, sum_q/carry_q SHALL capture the current sum/carry, and out_valid SHALL be 1 in the following cycle.
REQ-020 On a rising clk edge with en=0, sum_q/carry_q SHALL hold their value and out_valid SHALL become 0.
REQ-021 out_valid SHALL go high exactly one cycle after each en cycle; back-to-back en cycles SHALL keep out_valid continuously high.
REQ-022 Boundary: all-ones + all-ones + cin=1 SHALL give sum = all-ones and carry = 1; all-zeros + cin=0 SHALL give all zeros.
REQ-023 Input changes between edges SHALL NOT affect sum_q, carry_q or out_valid.
REQ-024 With REG_OUT=0, sum_q, carry_q and out_valid SHALL be constant 0.

Reset
REQ-025 rst_n=0 SHALL immediately clear sum_q, carry_q and out_valid to 0, without waiting for a clock edge.
REQ-026 Reset asserted in the middle of operation SHALL override en.
REQ-027 The first capture after rst_n deasserts SHALL happen on the first rising edge with en=1.
REQ-028 Reset SHALL NOT affect the combinational sum/carry.

Structure
REQ-029 A shared package SHALL hold the default WIDTH constant and the WIDTH legal range limits.
REQ-030 One sub-module, fa_cell, SHALL implement the 1-bit full adder (a, b, cin -> sum, carry); the top SHALL instantiate WIDTH copies in a generate loop.
REQ-031 The top SHALL contain the register stage and a parameter-range check that fails elaboration for WIDTH outside 1..64.

Verification
REQ-032 WIDTH=1: drive all 8 combinations of (a, b, cin) from 000 to 111, one per 10 ns -> sum/carry = 00, 10, 10, 01, 10, 01, 01, 11 (sum listed first).
REQ-033 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1 combinationally; sum_q=0x00, carry_q=1 and out_valid=1 one cycle after en.
REQ-034 WIDTH=8: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
REQ-035 Pulse en for one cycle with a=3, b=4, then change the inputs with en=0 -> sum_q stays 7, and out_valid is 1 for exactly one cycle.
REQ-036 Assert rst_n=0 between clock edges while out_valid=1 -> sum_q, carry_q and out_valid drop to 0 immediately, while combinational sum is unchanged.
REQ-037 Random a, b, cin for 1000 cycles with random en -> every result matches the a+b+cin reference, and the registered path matches with one-cycle latency.
